or16_accum: RTL and testbench

//   Stream OR-reduction stage that sits directly downstream of the Or16 gate.
//   Or16 combines each incoming word with a running accumulator register. The

---
 rtl/or16_accum.sv | 143 ++++++++++++++
 tb/tb_or16_accum.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/or16_accum.sv
// ----------------------------------------------------------------------------
// or16_accum
//   Stream OR-reduction stage. Each accepted input word is ORed into a running
//   accumulator through the Or16 gate. When the programmed number of words has
//   been absorbed, the result is held on a valid/ready output port until the
//   consumer takes it. Only one job is in flight at a time.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low
//   start      in   open a job (sampled only in IDLE)
//   count      in   number of words in the job (sampled with start)
//   in_valid   in   in_data holds a word
//   in_ready   out  block accepts in_data this cycle
//   in_data    in   input word, bit 0 = MSB
//   out_valid  out  out_data holds the job result
//   out_ready  in   consumer takes the result this cycle
//   out_data   out  OR of all words of the job, 0 while out_valid=0
//   busy       out  job in progress (ACCUM or DONE)
// ----------------------------------------------------------------------------

// Or16: 16-bit bitwise OR gate.
module or16 (
   input  logic [0:15] i_a,
   input  logic [0:15] i_b,
   output logic [0:15] o_y
);
   assign o_y = i_a | i_b;
endmodule

// State table
//   state   | meaning
//   S_IDLE  | no job; waiting for start
//   S_ACCUM | absorbing words; in_ready=1
//   S_DONE  | result presented; waiting for out_ready
module or16_accum #(
   parameter int WIDTH   = 16,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] count,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [0:WIDTH-1]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:WIDTH-1]   out_data,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [0:WIDTH-1]   r_acc;
   logic [0:WIDTH-1]   w_acc_nxt;
   logic [COUNT_W-1:0] r_remaining;
   logic [COUNT_W-1:0] w_remaining_nxt;
   logic [0:WIDTH-1]   w_or;

   // Use the Or16 gate when the word width matches; otherwise a plain OR.
   generate
      if (WIDTH == 16) begin : g_or16
         or16 u_or16 (
            .i_a (r_acc),
            .i_b (in_data),
            .o_y (w_or)
         );
      end else begin : g_or_generic
         assign w_or = r_acc | in_data;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_remaining <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_remaining <= w_remaining_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_remaining_nxt = r_remaining;
      in_ready        = 1'b0;
      out_valid       = 1'b0;
      out_data        = '0;
      busy            = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_acc_nxt = '0;
               if (count != '0) begin
                  w_remaining_nxt = count;
                  w_state_nxt     = S_ACCUM;
               end else begin
                  // Empty job: result is 0, present it immediately.
                  w_state_nxt = S_DONE;
               end
            end
         end

         S_ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               w_acc_nxt       = w_or;
               // r_remaining is always >= 1 here, so this cannot wrap.
               w_remaining_nxt = r_remaining - COUNT_W'(1);
               if (r_remaining == COUNT_W'(1)) begin
                  w_state_nxt = S_DONE;
               end
            end
         end

         S_DONE: begin
            out_valid = 1'b1;
            out_data  = r_acc;
            busy      = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_or16_accum.sv
module tb_or16_accum;

   localparam int WIDTH   = 16;
   localparam int COUNT_W = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [COUNT_W-1:0] count;
   logic               in_valid;
   logic               in_ready;
   logic [0:WIDTH-1]   in_data;
   logic               out_valid;
   logic               out_ready;
   logic [0:WIDTH-1]   out_data;
   logic               busy;

   int n_tests = 0;
   int n_fail  = 0;
   int xfers   = 0;

   logic [15:0] q_words[$];

   or16_accum #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .count     (count),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Independent transfer counter: a transfer is a rising edge with valid&&ready.
   always @(posedge clk) begin
      if (in_valid && in_ready) xfers++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one job with the words in q_words. Reference result is the plain OR
   // of every word. gap<0 picks random idle gaps of 0..2 cycles between words.
   task automatic run_job(input int gap, input int hold, input bit hold_start,
                          input bit hold_valid);
      logic [15:0] exp_v;
      int n;
      int x0;
      int g;
      exp_v = 16'h0000;
      n = q_words.size();
      foreach (q_words[i]) exp_v = exp_v | q_words[i];

      @(negedge clk);
      start = 1'b1;
      count = COUNT_W'(n);
      @(negedge clk);
      start = 1'b0;
      count = COUNT_W'($urandom);
      x0 = xfers;
      if (n == 0) check("empty_no_ready", in_ready, 1'b0);
      else        check("accum_busy", busy, 1'b1);

      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = q_words[i];
         check("word_ready", in_ready, 1'b1);
         check("early_valid", out_valid, 1'b0);
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 16'($urandom);
         if (i != n - 1) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
               start = 1'($urandom_range(0, 1));
               count = '0;
               check("gap_ready", in_ready, 1'b1);
               check("gap_valid", out_valid, 1'b0);
               @(negedge clk);
            end
            start = 1'b0;
         end
      end

      check("xfer_count", xfers - x0, n);
      check("out_valid", out_valid, 1'b1);
      check("out_data", out_data, exp_v);
      check("done_busy", busy, 1'b1);
      check("done_ready", in_ready, 1'b0);

      repeat (hold) begin
         out_ready = 1'b0;
         start     = hold_start;
         count     = COUNT_W'($urandom);
         in_valid  = hold_valid;
         in_data   = 16'($urandom);
         @(negedge clk);
         check("hold_valid", out_valid, 1'b1);
         check("hold_data", out_data, exp_v);
         check("hold_busy", busy, 1'b1);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      if (hold_valid) check("hold_xfers", xfers - x0, n);

      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_valid", out_valid, 1'b0);
      check("idle_data", out_data, 16'h0000);
      check("idle_busy", busy, 1'b0);
      check("idle_ready", in_ready, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      count     = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_ready", in_ready, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 16'h0000);
      check("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);

      // Three words back-to-back
      q_words = '{16'h8000, 16'h0001, 16'h00F0};
      run_job(0, 0, 1'b0, 1'b0);

      // Empty job
      q_words.delete();
      run_job(0, 0, 1'b0, 1'b0);

      // Idle gaps of 3 cycles between words
      q_words = '{16'h1200, 16'h0034};
      run_job(3, 0, 1'b0, 1'b0);

      // Output back-pressure for 5 cycles with start pulsed
      q_words = '{16'($urandom), 16'($urandom)};
      run_job(0, 5, 1'b1, 1'b0);

      // Reset in the middle of a job
      @(negedge clk);
      start = 1'b1;
      count = COUNT_W'(4);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'hF000;
      @(negedge clk);
      in_data  = 16'h00F0;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_ready", in_ready, 1'b0);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_data", out_data, 16'h0000);
      check("midrst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      q_words = '{16'h0F0F};
      run_job(0, 0, 1'b0, 1'b0);

      // Random jobs
      repeat (6) begin
         q_words.delete();
         repeat ($urandom_range(1, 12)) q_words.push_back(16'($urandom));
         run_job(-1, int'($urandom_range(0, 3)), 1'b1, 1'b0);
      end

      // Maximum-length job with in_valid kept high after the last word
      q_words.delete();
      for (int i = 0; i < 255; i++) q_words.push_back((i % 2 == 0) ? 16'hAAAA : 16'h5555);
      run_job(0, 3, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
